ks_sum_seq: RTL and testbench

Back-end sum stage of the Kogge-Stone adder, and the consumer of the per-bit propagate/generate vectors built by the front-end PG stage and prefix tree. Per-bit carries come from the group generate/propagate vectors and carry-in. The stage forms the 16-bit sum and carry-out and registers them behind a valid/ready handshake with a 2-entry skid buffer. It also chains carries across consecutive 16-bit words so that wide (multiword) additions stream through one 16-bit datapath.

---
 rtl/ks_sum_seq_pkg.sv | 12 +
 rtl/ks_skid2.sv | 54 +++++
 rtl/ks_sum_seq.sv | 112 +++++++++++
 tb/tb_ks_sum_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_sum_seq_pkg.sv
// Shared definitions for the Kogge-Stone adder stages: word width and the
// sum-stage sequencing state encoding.
package ks_sum_seq_pkg;

  localparam int KS_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ks_skid2.sv
// Two-entry valid/ready skid buffer: one output register plus one skid entry.
// o_ready comes straight from a flop so upstream never sees a combinational path.
module ks_skid2 #(
  parameter int PW = 20
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_data
);

  logic          out_valid_reg;
  logic [PW-1:0] out_data_reg;
  logic          skid_valid_reg;
  logic [PW-1:0] skid_data_reg;
  logic          accept;
  logic          out_free;

  assign accept   = i_valid && !skid_valid_reg;
  assign out_free = !out_valid_reg || i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (skid_valid_reg && out_free) begin
      // Skid full implies no accept this cycle, so only the refill happens.
      out_data_reg   <= skid_data_reg;
      out_valid_reg  <= 1'b1;
      skid_valid_reg <= 1'b0;
    end else if (accept) begin
      if (out_free) begin
        out_data_reg  <= i_data;
        out_valid_reg <= 1'b1;
      end else begin
        skid_data_reg  <= i_data;
        skid_valid_reg <= 1'b1;
      end
    end else if (i_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign o_ready = !skid_valid_reg;
  assign o_valid = out_valid_reg;
  assign o_data  = out_data_reg;

endmodule

// File: rtl/ks_sum_seq.sv
// Kogge-Stone back-end sum stage: forms sum/carry from group G/P vectors,
// chains carries across words of a multiword add, and registers results.
module ks_sum_seq
  import ks_sum_seq_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_pk,
  input  logic [WIDTH-1:0] i_gg,
  input  logic [WIDTH-1:0] i_gp,
  input  logic             i_c0,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_last,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_seq_err
);

  localparam int PW = WIDTH + 4;

  seq_state_e       state_reg, state_next;
  logic             chain_c_reg;
  logic             zacc_reg;
  logic             seq_err_reg;
  logic             seq_err_set;
  logic             accept;
  logic             treat_first;
  logic             cin;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zacc_next;
  logic [PW-1:0]    payload;
  logic [PW-1:0]    out_payload;

  assign accept      = i_valid && o_ready;
  assign treat_first = (state_reg == ST_IDLE) || i_first;
  assign cin         = treat_first ? i_c0 : chain_c_reg;

  assign carry[0] = cin;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi] = i_gg[gi-1] | (i_gp[gi-1] & cin);
    end
  endgenerate

  assign sum       = i_pk ^ carry;
  assign cout      = i_gg[WIDTH-1] | (i_gp[WIDTH-1] & cin);
  assign ovf       = carry[WIDTH-1] ^ cout;
  assign zacc_next = treat_first ? (sum == '0) : (zacc_reg && (sum == '0));

  // Zero and overflow describe the whole operation, so only the last word carries them.
  assign payload = {sum, cout, i_last, i_last && zacc_next, i_last && ovf};

  always_comb begin
    state_next  = state_reg;
    seq_err_set = 1'b0;
    if (accept) begin
      seq_err_set = (state_reg == ST_IDLE) ? !i_first : i_first;
      state_next  = i_last ? ST_IDLE : ST_CHAIN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      chain_c_reg <= 1'b0;
      zacc_reg    <= 1'b0;
      seq_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        chain_c_reg <= i_last ? 1'b0 : cout;
        zacc_reg    <= zacc_next;
      end
      if (seq_err_set) begin
        seq_err_reg <= 1'b1;
      end
    end
  end

  ks_skid2 #(
    .PW(PW)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (payload),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (out_payload)
  );

  assign o_sum     = out_payload[PW-1 -: WIDTH];
  assign o_cout    = out_payload[3];
  assign o_last    = out_payload[2];
  assign o_zero    = out_payload[1];
  assign o_ovf     = out_payload[0];
  assign o_seq_err = seq_err_reg;

endmodule

// File: tb/tb_ks_sum_seq.sv
// Directed self-checking bench for ks_sum_seq; operands are turned into
// pk/gg/gp by a small ripple prefix model, expected results are hand-computed.
module tb_ks_sum_seq;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_c0 = 1'b0;
  logic         i_first = 1'b0;
  logic         i_last = 1'b0;
  logic         i_ready = 1'b1;
  logic [W-1:0] i_pk = '0;
  logic [W-1:0] i_gg = '0;
  logic [W-1:0] i_gp = '0;
  logic         o_ready, o_valid, o_cout, o_last, o_zero, o_ovf, o_seq_err;
  logic [W-1:0] o_sum;
  logic [20:0]  obs;

  int checks = 0;
  int errors = 0;

  // Observed result vector: {valid, last, cout, zero, ovf, sum}
  assign obs = {o_valid, o_last, o_cout, o_zero, o_ovf, o_sum};

  always #5 i_clk = ~i_clk;

  ks_sum_seq dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_pk      (i_pk),
    .i_gg      (i_gg),
    .i_gp      (i_gp),
    .i_c0      (i_c0),
    .i_first   (i_first),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sum     (o_sum),
    .o_cout    (o_cout),
    .o_last    (o_last),
    .o_zero    (o_zero),
    .o_ovf     (o_ovf),
    .o_seq_err (o_seq_err)
  );

  task automatic set_word(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c0, input logic first, input logic last);
    logic [W-1:0] g, p, gg, gp;
    g = a & b;
    p = a ^ b;
    gg[0] = g[0];
    gp[0] = p[0];
    for (int i = 1; i < W; i++) begin
      gg[i] = g[i] | (p[i] & gg[i-1]);
      gp[i] = p[i] & gp[i-1];
    end
    i_pk = p; i_gg = gg; i_gp = gp;
    i_c0 = c0; i_first = first; i_last = last; i_valid = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
    end
    checks++;
    if ({o_ready, o_seq_err} !== 2'b10) begin
      errors++; $display("FAIL reset_ready_err: got %b expected 10", {o_ready, o_seq_err});
    end
    $display("txn reset: obs=%h ready=%b err=%b", obs, o_ready, o_seq_err);
    i_rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge i_clk) set_word(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1);
    @(negedge i_clk) i_valid = 1'b0;
    checks++;
    if (obs !== {5'b11000, 16'h0100}) begin
      errors++; $display("FAIL single_word: got %h expected %h", obs, {5'b11000, 16'h0100});
    end
    checks++;
    if (o_seq_err !== 1'b0) begin
      errors++; $display("FAIL single_no_err: got %b expected 0", o_seq_err);
    end
    $display("txn single 00FF+0001: sum=%h cout=%b", o_sum, o_cout);
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL single_drained: got valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_ovf_zero();
    @(negedge i_clk) set_word(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    @(negedge i_clk) set_word(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== {5'b11001, 16'h8000}) begin
      errors++; $display("FAIL signed_ovf: got %h expected %h", obs, {5'b11001, 16'h8000});
    end
    $display("txn 7FFF+0001: sum=%h ovf=%b", o_sum, o_ovf);
    @(negedge i_clk) i_valid = 1'b0;
    checks++;
    if (obs !== {5'b11110, 16'h0000}) begin
      errors++; $display("FAIL wrap_zero: got %h expected %h", obs, {5'b11110, 16'h0000});
    end
    $display("txn FFFF+0001: sum=%h cout=%b zero=%b", o_sum, o_cout, o_zero);
  endtask

  task automatic test_chain();
    @(negedge i_clk) set_word(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    @(negedge i_clk) set_word(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== {5'b10100, 16'h0000}) begin
      errors++; $display("FAIL chain_low: got %h expected %h", obs, {5'b10100, 16'h0000});
    end
    $display("txn chain low: sum=%h cout=%b", o_sum, o_cout);
    @(negedge i_clk) set_word(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== {5'b11000, 16'h0001}) begin
      errors++; $display("FAIL chain_high: got %h expected %h", obs, {5'b11000, 16'h0001});
    end
    $display("txn chain high: sum=%h last=%b", o_sum, o_last);
    // 0x0001_0000 + 0xFFFF_0000 wraps to zero across both words
    @(negedge i_clk) set_word(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {5'b11010, 16'h0000}) begin
      errors++; $display("FAIL no_stale_carry: got %h expected %h", obs, {5'b11010, 16'h0000});
    end
    $display("txn fresh single: sum=%h zero=%b", o_sum, o_zero);
    @(negedge i_clk) set_word(16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== {5'b10000, 16'h0000}) begin
      errors++; $display("FAIL zchain_low: got %h expected %h", obs, {5'b10000, 16'h0000});
    end
    $display("txn zero chain low: sum=%h zero=%b", o_sum, o_zero);
    @(negedge i_clk) i_valid = 1'b0;
    checks++;
    if (obs !== {5'b11110, 16'h0000}) begin
      errors++; $display("FAIL zchain_high: got %h expected %h", obs, {5'b11110, 16'h0000});
    end
    checks++;
    if (o_seq_err !== 1'b0) begin
      errors++; $display("FAIL chain_no_err: got %b expected 0", o_seq_err);
    end
    $display("txn zero chain high: sum=%h cout=%b zero=%b", o_sum, o_cout, o_zero);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_sum [4];
    int sent;
    int rcv;
    exp_sum[0] = 16'h0011; exp_sum[1] = 16'h0012;
    exp_sum[2] = 16'h0013; exp_sum[3] = 16'h0014;
    sent = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge i_clk);
      if (sent < 4) set_word(W'(sent + 1), 16'h0010, 1'b0, 1'b1, 1'b1);
      else i_valid = 1'b0;
      i_ready = (cyc >= 3);
      if (cyc == 2) begin
        checks++;
        if (o_ready !== 1'b0 || sent != 2) begin
          errors++; $display("FAIL bp_ready_low: got ready=%b sent=%0d expected 0/2", o_ready, sent);
        end
      end
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if ({o_valid, o_sum} !== {1'b1, 16'h0011}) begin
          errors++; $display("FAIL bp_hold: got %h expected %h", {o_valid, o_sum}, {1'b1, 16'h0011});
        end
      end
      if (cyc == 4) begin
        checks++;
        if (o_ready !== 1'b1) begin
          errors++; $display("FAIL bp_ready_back: got %b expected 1", o_ready);
        end
      end
      if (i_valid && o_ready) sent++;
      if (o_valid && i_ready) begin
        checks++;
        if (rcv >= 4 || o_sum !== exp_sum[rcv & 3]) begin
          errors++; $display("FAIL bp_order: got %h index %0d", o_sum, rcv);
        end else begin
          $display("txn bp word %0d: sum=%h", rcv, o_sum);
        end
        rcv++;
      end
    end
    checks++;
    if (sent != 4 || rcv != 4 || o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count: got sent=%0d rcv=%0d valid=%b expected 4/4/0", sent, rcv, o_valid);
    end
    i_ready = 1'b1;
  endtask

  task automatic test_framing();
    @(negedge i_clk) set_word(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk) set_word(16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({obs, o_seq_err} !== {5'b10100, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL frame_first: got %h err=%b expected %h err=1", obs, o_seq_err, {5'b10100, 16'h0000});
    end
    $display("txn frame no-first: sum=%h err=%b", o_sum, o_seq_err);
    @(negedge i_clk) i_valid = 1'b0;
    checks++;
    if ({obs, o_seq_err} !== {5'b11000, 16'h0010, 1'b1}) begin
      errors++; $display("FAIL frame_restart: got %h err=%b expected %h err=1", obs, o_seq_err, {5'b11000, 16'h0010});
    end
    $display("txn frame restart: sum=%h err=%b", o_sum, o_seq_err);
  endtask

  task automatic test_reset_mid_chain();
    @(negedge i_clk) set_word(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    @(negedge i_clk) begin
      i_valid = 1'b0;
      i_rst = 1'b1;
    end
    #1;
    checks++;
    if ({obs, o_ready, o_seq_err} !== {21'h0, 2'b10}) begin
      errors++; $display("FAIL midrst_outputs: got %h ready=%b err=%b expected 0/1/0", obs, o_ready, o_seq_err);
    end
    @(negedge i_clk) i_rst = 1'b0;
    @(negedge i_clk) set_word(16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1);
    @(negedge i_clk) i_valid = 1'b0;
    checks++;
    if ({obs, o_seq_err} !== {5'b11000, 16'h0008, 1'b0}) begin
      errors++; $display("FAIL midrst_next: got %h err=%b expected %h err=0", obs, o_seq_err, {5'b11000, 16'h0008});
    end
    $display("txn after reset: sum=%h err=%b", o_sum, o_seq_err);
  endtask

  initial begin
    test_reset();
    test_single();
    test_ovf_zero();
    test_chain();
    test_back_to_back();
    test_framing();
    test_reset_mid_chain();
    repeat (2) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
